fft8_frame_ctrl: RTL and testbench

Frame sequencer for the 8-point combinational radix-2 transform cores (forward and inverse, Q16.16 complex, 32-bit). It collects one frame of 8 complex samples from a valid/ready input stream and presents them in parallel to the core. After a fixed settling time it captures the core outputs and replays them as a serial valid/ready output stream. It sits between the sample source/sink and the transform core and owns all sequencing, framing and direction selection.

---
 rtl/fft8_frame_ctrl.sv | 151 +++++++++++++++
 tb/tb_fft8_frame_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft8_frame_ctrl.sv
// Frame sequencer for the 8-point combinational transform core: gathers a frame
// from the input stream, holds it on the core for CORE_LAT cycles, then streams results out.
module fft8_frame_ctrl #(
  parameter int unsigned DW       = 32,
  parameter int unsigned N        = 8,
  parameter int unsigned CORE_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DW-1:0]     s_re,
  input  logic [DW-1:0]     s_im,
  input  logic              s_last,
  input  logic              s_inv,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DW-1:0]     m_re,
  output logic [DW-1:0]     m_im,
  output logic              m_last,
  output logic [N*DW-1:0]   core_inr,
  output logic [N*DW-1:0]   core_ini,
  output logic              core_inv,
  input  logic [N*DW-1:0]   core_outr,
  input  logic [N*DW-1:0]   core_outi,
  output logic              err_len,
  output logic              busy
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = (CORE_LAT < 2) ? 1 : $clog2(CORE_LAT + 1);

  localparam logic [1:0] LOAD    = 2'd0;
  localparam logic [1:0] COMPUTE = 2'd1;
  localparam logic [1:0] UNLOAD  = 2'd2;

  logic [1:0]    state, state_n;
  logic [IW-1:0] idx, oidx, oidx_nx;
  logic [CW-1:0] cnt;
  logic          inv_r;
  logic [DW-1:0] ibuf_re [N];
  logic [DW-1:0] ibuf_im [N];
  logic [DW-1:0] obuf_re [N];
  logic [DW-1:0] obuf_im [N];
  logic          in_hs, out_hs, frame_end, cap, idx_full;

  assign in_hs     = s_valid & s_ready;
  assign out_hs    = m_valid & m_ready;
  assign idx_full  = (idx == IW'(N - 1));
  assign frame_end = in_hs & (s_last | idx_full);
  assign cap       = (state == COMPUTE) && (cnt == CW'(1));
  assign oidx_nx   = oidx + IW'(1);
  assign core_inv  = inv_r;

  // Core inputs come straight from the frame registers only
  for (genvar k = 0; k < N; k++) begin : g_pack
    assign core_inr[k*DW +: DW] = ibuf_re[k];
    assign core_ini[k*DW +: DW] = ibuf_im[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      LOAD:    if (frame_end) state_n = COMPUTE;
      COMPUTE: if (cap) state_n = UNLOAD;
      UNLOAD:  if (out_hs && (oidx == IW'(N - 1))) state_n = LOAD;
      default: state_n = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      oidx    <= '0;
      cnt     <= '0;
      inv_r   <= 1'b0;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_re    <= '0;
      m_im    <= '0;
      err_len <= 1'b0;
      busy    <= 1'b0;
      for (int i = 0; i < N; i++) begin
        ibuf_re[i] <= '0;
        ibuf_im[i] <= '0;
        obuf_re[i] <= '0;
        obuf_im[i] <= '0;
      end
    end else begin
      s_ready <= (state_n == LOAD);
      busy    <= (state_n != LOAD);
      err_len <= 1'b0;

      if (in_hs) begin
        ibuf_re[idx] <= s_re;
        ibuf_im[idx] <= s_im;
        idx          <= idx + IW'(1);
        if (idx == '0) inv_r <= s_inv;
      end

      // Length error: early s_last, or a full frame without s_last
      if (frame_end) begin
        cnt     <= CW'(CORE_LAT);
        err_len <= s_last ^ idx_full;
      end

      if (state == COMPUTE) begin
        if (cap) begin
          for (int k = 0; k < N; k++) begin
            obuf_re[k] <= core_outr[k*DW +: DW];
            obuf_im[k] <= core_outi[k*DW +: DW];
          end
          m_valid <= 1'b1;
          m_re    <= core_outr[DW-1:0];
          m_im    <= core_outi[DW-1:0];
          m_last  <= 1'b0;
          oidx    <= '0;
        end else begin
          cnt <= cnt - CW'(1);
        end
      end

      if (out_hs) begin
        if (oidx == IW'(N - 1)) begin
          m_valid <= 1'b0;
          m_last  <= 1'b0;
          m_re    <= '0;
          m_im    <= '0;
          oidx    <= '0;
          idx     <= '0;
          for (int i = 0; i < N; i++) begin
            ibuf_re[i] <= '0;
            ibuf_im[i] <= '0;
          end
        end else begin
          oidx   <= oidx_nx;
          m_re   <= obuf_re[oidx_nx];
          m_im   <= obuf_im[oidx_nx];
          m_last <= (oidx_nx == IW'(N - 1));
        end
      end
    end
  end

endmodule

// File: tb/tb_fft8_frame_ctrl.sv
// Directed bench for fft8_frame_ctrl with an identity core model wired back
// from core_in* to core_out*.
module tb_fft8_frame_ctrl;
  localparam int unsigned DW = 32;
  localparam int unsigned N  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            s_valid, s_ready, s_last, s_inv;
  logic [DW-1:0]   s_re, s_im;
  logic            m_valid, m_ready, m_last;
  logic [DW-1:0]   m_re, m_im;
  logic [N*DW-1:0] core_inr, core_ini, core_outr, core_outi;
  logic            core_inv, err_len, busy;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0]   tx_re [N];
  logic [DW-1:0]   tx_im [N];
  logic [DW-1:0]   exp_re [N];
  logic [DW-1:0]   exp_im [N];
  logic [N*DW-1:0] ev_r, ev_i;

  fft8_frame_ctrl #(.DW(DW), .N(N), .CORE_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im),
    .s_last(s_last), .s_inv(s_inv),
    .m_valid(m_valid), .m_ready(m_ready), .m_re(m_re), .m_im(m_im), .m_last(m_last),
    .core_inr(core_inr), .core_ini(core_ini), .core_inv(core_inv),
    .core_outr(core_outr), .core_outi(core_outi),
    .err_len(err_len), .busy(busy)
  );

  assign core_outr = core_inr;
  assign core_outi = core_ini;

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy_pat(input int c);
    return ((c % 4) == 0) || ((c % 4) == 3);
  endfunction

  // Expected = zero-padded copy of the first n transmitted samples (identity core)
  task automatic set_expect(input int n);
    for (int k = 0; k < N; k++) begin
      exp_re[k] = (k < n) ? tx_re[k] : '0;
      exp_im[k] = (k < n) ? tx_im[k] : '0;
      ev_r[k*DW +: DW] = exp_re[k];
      ev_i[k*DW +: DW] = exp_im[k];
    end
  endtask

  task automatic send(input int n, input int last_at, input logic inv0);
    int guard;
    for (int k = 0; k < n; k++) begin
      s_valid = 1'b1;
      s_re    = tx_re[k];
      s_im    = tx_im[k];
      s_last  = (k == last_at);
      s_inv   = (k == 0) ? inv0 : ~inv0;
      guard   = 0;
      while (!s_ready && guard < 100) begin
        step();
        guard++;
      end
      total++;
      if (s_ready !== 1'b1) begin
        bad++;
        $display("FAIL send_ready k=%0d got s_ready=%b want 1", k, s_ready);
      end
      step();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_inv   = 1'b0;
    s_re    = '0;
    s_im    = '0;
  endtask

  task automatic recv(input int nhs, input logic use_pat, input logic exp_inv);
    int o;
    int cyc;
    o   = 0;
    cyc = 0;
    while (o < nhs && cyc < 200) begin
      m_ready = use_pat ? rdy_pat(cyc) : 1'b1;
      if (m_valid === 1'b1) begin
        total++;
        if (m_re !== exp_re[o] || m_im !== exp_im[o] || m_last !== (o == N - 1)) begin
          bad++;
          $display("FAIL recv_data o=%0d got re=%h im=%h last=%b want re=%h im=%h last=%b",
                   o, m_re, m_im, m_last, exp_re[o], exp_im[o], (o == N - 1));
        end
        total++;
        if (s_ready !== 1'b0 || busy !== 1'b1 || core_inv !== exp_inv) begin
          bad++;
          $display("FAIL recv_ctrl o=%0d got s_ready=%b busy=%b core_inv=%b want 0 1 %b",
                   o, s_ready, busy, core_inv, exp_inv);
        end
        if (m_ready) o++;
      end
      step();
      cyc++;
    end
    m_ready = 1'b0;
    total++;
    if (o != nhs) begin
      bad++;
      $display("FAIL recv_count got %0d handshakes want %0d", o, nhs);
    end
  endtask

  task automatic check_idle(input string tag);
    total++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle got s_ready=%b m_valid=%b busy=%b want 1 0 0",
               tag, s_ready, m_valid, busy);
    end
  endtask

  task automatic check_core(input string tag, input logic inv);
    total++;
    if (core_inr !== ev_r || core_ini !== ev_i || core_inv !== inv) begin
      bad++;
      $display("FAIL %s_core got inr=%h inv=%b want inr=%h inv=%b", tag, core_inr, core_inv, ev_r, inv);
    end
  endtask

  task automatic check_err(input string tag, input logic e);
    total++;
    if (err_len !== e) begin
      bad++;
      $display("FAIL %s_err got err_len=%b want %b", tag, err_len, e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++;
    if (s_ready !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0 || m_re !== '0 || m_im !== '0 ||
        err_len !== 1'b0 || busy !== 1'b0 || core_inv !== 1'b0 || core_inr !== '0 || core_ini !== '0) begin
      bad++;
      $display("FAIL reset_vals got s_ready=%b m_valid=%b m_re=%h busy=%b err=%b inv=%b want all 0",
               s_ready, m_valid, m_re, busy, err_len, core_inv);
    end
    rst = 1'b0;
    step();
    check_idle("reset");
  endtask

  task automatic test_impulse();
    for (int k = 0; k < N; k++) begin
      tx_re[k] = (k == 0) ? 32'h0001_0000 : '0;
      tx_im[k] = '0;
    end
    set_expect(N);
    send(N, N - 1, 1'b0);
    check_core("impulse", 1'b0);
    check_err("impulse", 1'b0);
    total++;
    if (m_valid !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL impulse_lat1 got m_valid=%b busy=%b want 0 1", m_valid, busy);
    end
    step();
    total++;
    if (m_valid !== 1'b1 || m_re !== 32'h0001_0000) begin
      bad++;
      $display("FAIL impulse_lat2 got m_valid=%b m_re=%h want 1 00010000", m_valid, m_re);
    end
    recv(N, 1'b0, 1'b0);
    check_idle("impulse");
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < N; k++) begin
      tx_re[k] = DW'(k) << 16;
      tx_im[k] = DW'(k * 3 + 1);
    end
    set_expect(N);
    send(N, N - 1, 1'b0);
    recv(N, 1'b1, 1'b0);
    check_idle("backpressure");
  endtask

  task automatic test_early_last();
    for (int k = 0; k < N; k++) begin
      tx_re[k] = 32'h0001_0000;
      tx_im[k] = DW'(32'h10 + k);
    end
    set_expect(3);
    send(3, 2, 1'b0);
    check_core("early_last", 1'b0);
    check_err("early_last_pulse", 1'b1);
    step();
    check_err("early_last_clear", 1'b0);
    recv(N, 1'b0, 1'b0);
    check_idle("early_last");
  endtask

  task automatic test_missing_last();
    for (int k = 0; k < N; k++) begin
      tx_re[k] = DW'(32'hA000_0000 + k);
      tx_im[k] = DW'(32'h5000_0000 - k);
    end
    set_expect(N);
    send(N, -1, 1'b0);
    check_core("missing_last", 1'b0);
    check_err("missing_last_pulse", 1'b1);
    step();
    check_err("missing_last_clear", 1'b0);
    recv(N, 1'b1, 1'b0);
    check_idle("missing_last");
  endtask

  task automatic test_inverse();
    for (int k = 0; k < N; k++) begin
      tx_re[k] = DW'(32'hFFFF_0000 - (k << 16));
      tx_im[k] = DW'(k << 12);
    end
    set_expect(N);
    send(N, N - 1, 1'b1);
    check_core("inverse", 1'b1);
    recv(N, 1'b0, 1'b1);
    send(N, N - 1, 1'b0);
    check_core("forward_again", 1'b0);
    recv(N, 1'b0, 1'b0);
    check_idle("inverse");
  endtask

  task automatic test_reset_mid_unload();
    for (int k = 0; k < N; k++) begin
      tx_re[k] = DW'(32'h1234_0000 + k);
      tx_im[k] = DW'(32'h0000_4321 + k);
    end
    set_expect(N);
    send(N, N - 1, 1'b0);
    recv(3, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0) begin
      bad++;
      $display("FAIL midrst_async got m_valid=%b busy=%b s_ready=%b want 0 0 0", m_valid, busy, s_ready);
    end
    step();
    rst = 1'b0;
    step();
    check_idle("midrst");
    total++;
    if (core_inr !== '0 || core_ini !== '0) begin
      bad++;
      $display("FAIL midrst_stale got inr=%h want 0", core_inr);
    end
    for (int k = 0; k < N; k++) begin
      tx_re[k] = DW'(32'h0002_0000 * (k + 1));
      tx_im[k] = DW'(32'hFFFF_FFF0 + k);
    end
    set_expect(N);
    send(N, N - 1, 1'b0);
    check_core("midrst_fresh", 1'b0);
    recv(N, 1'b0, 1'b0);
    check_idle("midrst_fresh");
  endtask

  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    s_re    = '0;
    s_im    = '0;
    s_last  = 1'b0;
    s_inv   = 1'b0;
    m_ready = 1'b0;
    test_reset();
    test_impulse();
    test_backpressure();
    test_early_last();
    test_missing_last();
    test_inverse();
    test_reset_mid_unload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
